// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the core trace monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  typedef enum logic [1:0] {
    HALT_NONE = 2'b00,
    HALT_LOOP = 2'b01,
    HALT_STOP = 2'b10
  } halt_cause_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] rd;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Synchronous FIFO for retire records; drops pushes when full.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign o_valid    = (r_count != '0);
  assign w_full     = (r_count == c_full);
  assign w_pop      = o_valid && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr       = i_push && (!w_full || w_pop);
  assign o_data     = r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (i_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : core_trace_monitor
// Description : Observes the multi-cycle core: counts cycles/retires, detects
//               halt, and queues per-instruction retire records.
// Revision    : 1.0 - initial release
// ============================================================================
module core_trace_monitor
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int HALT_REPEAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [XLEN-1:0]               pc,
  input  logic [1:0]                    state,
  input  logic [XLEN-1:0]               rd,
  input  logic [XLEN-1:0]               stop_pc,
  input  logic                          stop_pc_en,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [XLEN-1:0]               trace_pc,
  output logic [XLEN-1:0]               trace_rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              retired,
  output logic [CNT_W-1:0]              cycles,
  output logic                          halted,
  output logic [1:0]                    halt_cause
);

  localparam int RW = $clog2(HALT_REPEAT + 1);

  logic [1:0]        r_state;
  logic [XLEN-1:0]   r_rd;
  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_fetch_vld;
  logic [RW-1:0]     r_rep;
  logic              r_halted;
  halt_cause_e       r_cause;
  logic [CNT_W-1:0]  r_cycles;
  logic [CNT_W-1:0]  r_retired;

  logic              w_fe;
  logic              w_re;
  logic              w_stop_hit;
  logic [RW-1:0]     w_rep_inc;
  logic [2*XLEN-1:0] w_head;

  // The first fetch after reset has no predecessor, so it enters but never retires.
  assign w_fe       = (state == ST_FETCH) && ((r_state != ST_FETCH) || !r_fetch_vld);
  assign w_re       = (state == ST_FETCH) && (r_state != ST_FETCH) && r_fetch_vld && !r_halted;
  assign w_stop_hit = stop_pc_en && (pc == stop_pc);
  assign w_rep_inc  = r_rep + RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_rd        <= '0;
      r_fetch_pc  <= '0;
      r_fetch_vld <= 1'b0;
      r_rep       <= '0;
      r_halted    <= 1'b0;
      r_cause     <= HALT_NONE;
      r_cycles    <= '0;
      r_retired   <= '0;
    end else begin
      r_state <= state;
      r_rd    <= rd;
      if (w_fe) begin
        r_fetch_pc  <= pc;
        r_fetch_vld <= 1'b1;
      end
      // Stop address wins over the self-loop check.
      if (w_fe && !r_halted) begin
        if (w_stop_hit) begin
          r_halted <= 1'b1;
          r_cause  <= HALT_STOP;
        end else if (r_fetch_vld) begin
          if (pc == r_fetch_pc) begin
            r_rep <= w_rep_inc;
            if (w_rep_inc == RW'(HALT_REPEAT)) begin
              r_halted <= 1'b1;
              r_cause  <= HALT_LOOP;
            end
          end else begin
            r_rep <= '0;
          end
        end
      end
      if (!r_halted && (r_cycles != '1)) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
      if (w_re && (r_retired != '1)) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  trace_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_re),
    .i_data     ({r_fetch_pc, r_rd}),
    .i_ready    (trace_ready),
    .o_valid    (trace_valid),
    .o_data     (w_head),
    .o_count    (fifo_count),
    .o_overflow (overflow)
  );

  assign trace_pc   = w_head[2*XLEN-1:XLEN];
  assign trace_rd   = w_head[XLEN-1:0];
  assign retired    = r_retired;
  assign cycles     = r_cycles;
  assign halted     = r_halted;
  assign halt_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_core_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_trace_monitor
// Description : Scoreboard bench for core_trace_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_trace_monitor;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [1:0]  state = '0;
  logic [31:0] rd = '0;
  logic [31:0] stop_pc = '0;
  logic        stop_pc_en = 1'b0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc;
  logic [31:0] trace_rd;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [31:0] retired;
  logic [31:0] cycles;
  logic        halted;
  logic [1:0]  halt_cause;

  core_trace_monitor #(
    .XLEN(32), .CNT_W(32), .FIFO_DEPTH(8), .HALT_REPEAT(2)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .state(state), .rd(rd),
    .stop_pc(stop_pc), .stop_pc_en(stop_pc_en),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .fifo_count(fifo_count),
    .overflow(overflow), .retired(retired), .cycles(cycles),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic [31:0] last_pc = '0;

  trace_entry_t sb[$];

  // Reference model of the monitor's registers.
  logic [1:0]  m_state_q;
  logic [31:0] m_rd_q, m_fetch_pc, m_retired, m_cycles;
  logic        m_fetch_vld, m_halted, m_overflow;
  logic [1:0]  m_cause;
  int          m_rep;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state_q = '0; m_rd_q = '0; m_fetch_pc = '0; m_retired = '0; m_cycles = '0;
    m_fetch_vld = 1'b0; m_halted = 1'b0; m_overflow = 1'b0; m_cause = '0; m_rep = 0;
    sb.delete();
  endtask

  task automatic cyc(input logic [31:0] p, input logic [1:0] s, input logic [31:0] r,
                     input logic rdy);
    logic fe, re;
    trace_entry_t e;
    @(negedge clk);
    rst = 1'b0; pc = p; state = s; rd = r; trace_ready = rdy;
    #1;
    chk("retired",    retired,             m_retired);
    chk("cycles",     cycles,              m_cycles);
    chk("halted",     32'(halted),         32'(m_halted));
    chk("halt_cause", 32'(halt_cause),     32'(m_cause));
    chk("fifo_count", 32'(fifo_count),     32'(sb.size()));
    chk("overflow",   32'(overflow),       32'(m_overflow));
    chk("valid",      32'(trace_valid),    32'(sb.size() != 0));
    if (trace_valid && trace_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("trace_pc", trace_pc, e.pc);
      chk("trace_rd", trace_rd, e.rd);
      n_pop++;
      last_pc = trace_pc;
    end
    fe = (s == 2'd0) && (m_state_q != 2'd0 || !m_fetch_vld);
    re = (s == 2'd0) && (m_state_q != 2'd0) && m_fetch_vld && !m_halted;
    if (re) begin
      if (sb.size() < 8) sb.push_back('{pc: m_fetch_pc, rd: m_rd_q});
      else m_overflow = 1'b1;
      if (m_retired != '1) m_retired++;
    end
    if (!m_halted && m_cycles != '1) m_cycles++;
    if (fe && !m_halted) begin
      if (stop_pc_en && p == stop_pc) begin
        m_halted = 1'b1; m_cause = 2'b10;
      end else if (m_fetch_vld) begin
        if (p == m_fetch_pc) begin
          m_rep++;
          if (m_rep == 2) begin m_halted = 1'b1; m_cause = 2'b01; end
        end else m_rep = 0;
      end
    end
    if (fe) begin m_fetch_pc = p; m_fetch_vld = 1'b1; end
    m_state_q = s; m_rd_q = r;
  endtask

  task automatic instr(input logic [31:0] p, input logic [31:0] r, input logic rdy);
    cyc(p, 2'd0, 32'hdead_0000, rdy);
    cyc(p, 2'd1, 32'hdead_0001, rdy);
    cyc(p, 2'd2, 32'hdead_0002, rdy);
    cyc(p, 2'd3, r, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(pc, 2'd1, 32'hbeef, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; state = 2'd0; pc = '0; rd = '0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid",   32'(trace_valid), 0);
    chk("reset_retired", retired, 0);
    chk("reset_cycles",  cycles, 0);

    // Three plain instructions
    do_reset();
    n_pop = 0;
    instr(0, 5, 1'b1); instr(1, 7, 1'b1); instr(2, 9, 1'b1);
    cyc(3, 2'd0, 0, 1'b1);
    idle(4, 1'b1);
    chk("t1_retired", retired, 3);
    chk("t1_halted",  32'(halted), 0);
    chk("t1_pops",    32'(n_pop), 3);
    chk("t1_last_pc", last_pc, 2);

    // Self-loop halt at pc 35
    do_reset();
    instr(34, 1, 1'b1); instr(35, 2, 1'b1); instr(35, 3, 1'b1);
    cyc(35, 2'd0, 0, 1'b1);
    idle(3, 1'b1);
    instr(36, 4, 1'b1);
    cyc(37, 2'd0, 0, 1'b1);
    idle(2, 1'b1);
    chk("t2_halted",  32'(halted), 1);
    chk("t2_cause",   32'(halt_cause), 32'(2'b01));
    chk("t2_retired", retired, 3);
    chk("t2_cycles",  cycles, 13);

    // Stop PC halt
    do_reset();
    stop_pc = 8; stop_pc_en = 1'b1;
    for (int i = 0; i < 8; i++) instr(i, 3 * i + 1, 1'b1);
    cyc(8, 2'd0, 0, 1'b1);
    idle(3, 1'b1);
    chk("t3_halted",  32'(halted), 1);
    chk("t3_cause",   32'(halt_cause), 32'(2'b10));
    chk("t3_retired", retired, 8);

    // Stop PC disabled
    do_reset();
    stop_pc_en = 1'b0;
    for (int i = 0; i < 10; i++) instr(i, i + 100, 1'b1);
    cyc(10, 2'd0, 0, 1'b1);
    idle(3, 1'b1);
    chk("t3b_halted",  32'(halted), 0);
    chk("t3b_retired", retired, 10);

    // Stop PC on the very first fetch
    do_reset();
    stop_pc = 0; stop_pc_en = 1'b1;
    cyc(0, 2'd0, 0, 1'b1);
    idle(2, 1'b1);
    chk("t3c_halted",  32'(halted), 1);
    chk("t3c_cause",   32'(halt_cause), 32'(2'b10));
    stop_pc_en = 1'b0;

    // Overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 10; i++) instr(i, i + 200, 1'b0);
    cyc(10, 2'd0, 0, 1'b0);
    idle(2, 1'b0);
    chk("t4_count",    32'(fifo_count), 8);
    chk("t4_overflow", 32'(overflow), 1);
    n_pop = 0;
    idle(12, 1'b1);
    chk("t4_pops",    32'(n_pop), 8);
    chk("t4_last_pc", last_pc, 7);

    // Full FIFO: push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) instr(i, i + 300, 1'b0);
    cyc(8, 2'd0, 0, 1'b0);
    idle(2, 1'b0);
    chk("t5_full", 32'(fifo_count), 8);
    cyc(8, 2'd1, 0, 1'b0); cyc(8, 2'd2, 0, 1'b0); cyc(8, 2'd3, 308, 1'b0);
    cyc(9, 2'd0, 0, 1'b1);
    idle(1, 1'b0);
    chk("t5_count",    32'(fifo_count), 8);
    chk("t5_overflow", 32'(overflow), 0);
    n_pop = 0;
    idle(12, 1'b1);
    chk("t5_pops",    32'(n_pop), 8);
    chk("t5_last_pc", last_pc, 8);

    // Asynchronous reset during execute of the 2nd instruction
    do_reset();
    instr(0, 11, 1'b0);
    cyc(1, 2'd0, 0, 1'b0); cyc(1, 2'd1, 0, 1'b0);
    @(negedge clk);
    state = 2'd2;
    #2 rst = 1'b1;
    #1;
    chk("t6_cycles",  cycles, 0);
    chk("t6_retired", retired, 0);
    chk("t6_count",   32'(fifo_count), 0);
    chk("t6_valid",   32'(trace_valid), 0);
    chk("t6_halted",  32'(halted), 0);
    chk("t6_pc",      trace_pc, 0);
    model_reset();
    @(negedge clk);
    state = 2'd0;
    instr(5, 55, 1'b0);
    idle(2, 1'b0);
    chk("t6_no_record", 32'(fifo_count), 0);
    chk("t6_retired2",  retired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
